ecpri_rx_parser: RTL and testbench
==================================

# ecpri_rx_parser

Byte-stream eCPRI receive parser that sits directly behind the Ethernet frame source (the same byte bus the pcap reader drives). It decodes the Ethernet and eCPRI common headers and extracts pc_id/seq_id. It then strips headers and padding and forwards the eCPRI payload tagged with a channel index derived from pc_id. Frames that fail the checks are dropped, and per-channel packet counters are maintained. It generalises the single-stream capture path to NUM_CH logical channels with header checking.

## Interface
- NUM_CH, 4: number of output channels; legal pc_id range is 0..NUM_CH-1.
- CNT_W, 32: width of each per-channel packet counter.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_sop/in_eop are qualified; gaps allowed, no back-pressure.
- in_data  in  8  frame byte, first byte is the destination MAC MSB.
- in_sop / in_eop  in  1  first / last byte of a frame (both set for a 1-byte frame).
- out_valid  out  1  payload byte valid.
- out_data  out  8  payload byte.
- out_sop / out_eop  out  1  first / last payload byte.
- out_err  out  1  valid only with out_eop; frame ended before payload_size was reached.
- out_abort  out  1  one-cycle pulse; in-flight payload discarded by a new in_sop.
- out_ch  out  $clog2(NUM_CH) (min 1)  channel of the current payload, stable from out_sop to out_eop.
- hdr_valid  out  1  one-cycle pulse; the hdr_* fields are valid.
- hdr_msg_type  out  8  eCPRI message type.
- hdr_payload_size  out  16  eCPRI payload size field.
- hdr_pc_id / hdr_seq_id  out  16  PC_ID (or RTC_ID), SEQ_ID.
- drop  out  1  one-cycle pulse; frame rejected.
- drop_reason  out  2  0 = ethertype, 1 = revision, 2 = header (type > 2 or size < 4), 3 = channel; held until the next drop.
- stat_sel  in  $clog2(NUM_CH)  counter select.
- stat_cnt  out  CNT_W  registered count for stat_sel (1-cycle latency).

## Operation
- FSM states: IDLE, ETH, VLAN, ECPRI, PAYLOAD, FLUSH.
  - in_sop in any state sets byte index 0 and enters ETH.
  - If the state was PAYLOAD, out_abort pulses.
- ETH: bytes 12..13 are compared with 0xAEFE, which leads to ECPRI.
  - 0x8100 leads to VLAN (macro permitting).
  - Anything else: drop, reason 0, go to FLUSH.
- ECPRI (offsets relative to the eCPRI header start):
  - Byte 0: bits [7:4] must equal 1, otherwise reason 1.
  - Byte 1: msg_type, which must be ≤ 2.
  - Bytes 2..3: payload_size, which must be ≥ 4.
  - Bytes 4..5: pc_id. pc_id ≥ NUM_CH gives reason 3.
  - Bytes 6..7: seq_id.
  - All checks are evaluated when byte 7 is accepted. hdr_valid pulses whether or not the frame is then dropped.
- PAYLOAD: forwards exactly payload_size−4 bytes, then FLUSH.
  - The counter is 16-bit. payload_size = 4 produces no output bytes and counts the packet immediately.
- FLUSH: discards bytes, including Ethernet padding, until in_eop, then IDLE.
- in_eop in ETH/VLAN/ECPRI gives drop reason 2.
- in_eop in PAYLOAD before the final byte: that byte goes out with out_eop = 1 and out_err = 1, and the packet is not counted.
- Counter cnt[out_ch] increments on out_eop with out_err = 0. It wraps at 2^CNT_W.
- Reset values: every output is 0, drop_reason is 0, all counters are 0, FSM is in IDLE.
- Reset mid-frame: the frame is lost, with no out_eop and no abort.

## Timing
- All outputs are registered.
- A payload byte accepted at cycle t appears on out_* at t+1.
- hdr_valid / drop pulse at t+1 after the deciding byte (seq_id LSB, the ethertype LSB, or the truncating in_eop).
- Earliest out_sop is one cycle after hdr_valid.
- Bytes with in_valid = 0 produce out_valid = 0. Gaps propagate one-for-one.
- stat_cnt reflects counter updates from cycle t at t+1 and stat_sel changes one cycle later.

## Configuration
- ECPRI_VLAN_EN defined: one 802.1Q tag is accepted.
  - ethertype 0x8100 → VLAN state, which skips 2 TCI bytes and checks the inner ethertype at bytes 16..17 against 0xAEFE.
  - All later offsets shift by 4.
- ECPRI_VLAN_EN undefined: the VLAN state is absent and 0x8100 drops with reason 0.

## Structure
- Package ecpri_pkg holds:
  - ETH_TYPE_ECPRI = 16'hAEFE and ETH_TYPE_VLAN = 16'h8100.
  - The ECPRI_REV = 4'h1 constant.
  - The message type enum (IQ = 0, BIT_SEQ = 1, RTC = 2).
  - The drop_reason enum.
  - The FSM state typedef.
- Sub-module ecpri_ch_counters: NUM_CH × CNT_W counter bank with increment port and registered stat_sel read.

## Test plan
- Valid frame, pc_id = 2, seq_id = 0x0105, payload_size = 20, 14 padding bytes: hdr_valid with the fields set, 16 payload bytes on out_ch = 2, out_eop on the 16th, padding not forwarded, cnt[2] = 1.
- Ethertype 0x0800: drop with reason 0, no out_valid, counters unchanged. Revision 2 gives reason 1. msg_type 5 gives reason 2.
- pc_id = NUM_CH (4): hdr_valid, then drop reason 3, no payload out.
- Frame truncated after 5 payload bytes of 16: 5th byte has out_eop = 1 and out_err = 1, and the counter is unchanged.
- in_sop arriving mid-payload: out_abort pulse, and the new frame parses normally. in_valid gaps inside the payload: output gaps match one-for-one.
- With ECPRI_VLAN_EN, a tagged frame forwards correctly. Without it, the same frame drops with reason 0.

Source files
------------

// File: rtl/ecpri_pkg.sv
// Shared constants and types for the eCPRI receive parser.
// Optional 802.1Q support is enabled by defining ECPRI_VLAN_EN.
package ecpri_pkg;

    localparam logic [15:0] ETH_TYPE_ECPRI = 16'hAEFE;
    localparam logic [15:0] ETH_TYPE_VLAN  = 16'h8100;
    localparam logic [3:0]  ECPRI_REV      = 4'h1;

    // Byte index of the last ethertype byte, untagged and tagged.
    localparam logic [4:0]  ETH_TYPE_END      = 5'd13;
    localparam logic [4:0]  VLAN_TYPE_END     = 5'd17;
    localparam logic [4:0]  ECPRI_HDR_LAST    = 5'd7;
    localparam logic [15:0] ECPRI_SIZE_HDR    = 16'd4;

    typedef enum logic [7:0] {
        MSG_IQ      = 8'd0,
        MSG_BIT_SEQ = 8'd1,
        MSG_RTC     = 8'd2
    } msg_type_e;

    typedef enum logic [1:0] {
        DROP_ETHERTYPE = 2'd0,
        DROP_REVISION  = 2'd1,
        DROP_HEADER    = 2'd2,
        DROP_CHANNEL   = 2'd3
    } drop_reason_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH,
        ST_VLAN,
        ST_ECPRI,
        ST_PAYLOAD,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/ecpri_ch_counters.sv
// Per-channel packet counter bank with a registered, one-cycle-latency read port.
module ecpri_ch_counters #(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [CH_W-1:0]  inc_ch,
    input  logic [CH_W-1:0]  stat_sel,
    output logic [CNT_W-1:0] stat_cnt
);

    logic [CNT_W-1:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is a handful of flops read by software, not a RAM, so every
            // entry is cleared on reset; a true memory would be left unreset.
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            stat_cnt <= '0;
        end else begin
            if (inc && (int'(inc_ch) < NUM_CH))
                cnt[inc_ch] <= cnt[inc_ch] + CNT_W'(1);
            stat_cnt <= (int'(stat_sel) < NUM_CH) ? cnt[stat_sel] : '0;
        end
    end

endmodule

// File: rtl/ecpri_rx_parser.sv
// eCPRI receive parser: checks Ethernet/eCPRI headers, forwards payload per channel.
// Define ECPRI_VLAN_EN to accept a single 802.1Q tag ahead of the eCPRI ethertype.
module ecpri_rx_parser
    import ecpri_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic             out_abort,
    output logic [CH_W-1:0]  out_ch,
    output logic             hdr_valid,
    output logic [7:0]       hdr_msg_type,
    output logic [15:0]      hdr_payload_size,
    output logic [15:0]      hdr_pc_id,
    output logic [15:0]      hdr_seq_id,
    output logic             drop,
    output logic [1:0]       drop_reason,
    input  logic [CH_W-1:0]  stat_sel,
    output logic [CNT_W-1:0] stat_cnt
);

    state_e        state;
    logic [4:0]    idx;
    logic [7:0]    type_msb;
    logic [7:0]    ecpri_b0;
    logic [7:0]    msg_q;
    logic [15:0]   size_q;
    logic [15:0]   pcid_q;
    logic [7:0]    seq_msb;
    logic [15:0]   rem;
    logic          first_q;
    logic          cnt_inc;
    logic [CH_W-1:0] cnt_ch;

    logic [15:0]   eth_type;
    logic          type_ok;
    logic          type_vlan;
    logic [4:0]    type_end_idx;
    state_e        rest_state;
    logic          hdr_fail;
    drop_reason_e  hdr_reason;

    assign eth_type     = {type_msb, in_data};
    assign type_ok      = (eth_type == ETH_TYPE_ECPRI);
    assign type_end_idx = (state == ST_VLAN) ? VLAN_TYPE_END : ETH_TYPE_END;
    assign rest_state   = in_eop ? ST_IDLE : ST_FLUSH;

`ifdef ECPRI_VLAN_EN
    // Only the outer ethertype may introduce a tag; a second tag is rejected.
    assign type_vlan = (eth_type == ETH_TYPE_VLAN) && (state == ST_ETH);
`else
    assign type_vlan = 1'b0;
`endif

    // Header verdict on the seq_id LSB; checks are prioritised in drop_reason order.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // can leave it unassigned and infer a latch.
        hdr_fail   = 1'b1;
        hdr_reason = DROP_REVISION;
        if (ecpri_b0[7:4] != ECPRI_REV)
            hdr_reason = DROP_REVISION;
        else if ((msg_q > MSG_RTC) || (size_q < ECPRI_SIZE_HDR))
            hdr_reason = DROP_HEADER;
        else if (pcid_q >= 16'(NUM_CH))
            hdr_reason = DROP_CHANNEL;
        else if (in_eop && (size_q != ECPRI_SIZE_HDR))
            hdr_reason = DROP_HEADER;
        else
            hdr_fail = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            idx              <= '0;
            type_msb         <= '0;
            ecpri_b0         <= '0;
            msg_q            <= '0;
            size_q           <= '0;
            pcid_q           <= '0;
            seq_msb          <= '0;
            rem              <= '0;
            first_q          <= 1'b0;
            cnt_inc          <= 1'b0;
            cnt_ch           <= '0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_sop          <= 1'b0;
            out_eop          <= 1'b0;
            out_err          <= 1'b0;
            out_abort        <= 1'b0;
            out_ch           <= '0;
            hdr_valid        <= 1'b0;
            hdr_msg_type     <= '0;
            hdr_payload_size <= '0;
            hdr_pc_id        <= '0;
            hdr_seq_id       <= '0;
            drop             <= 1'b0;
            drop_reason      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the pulse defaults
            // below are overridden by any later assignment in the same cycle.
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_err   <= 1'b0;
            out_abort <= 1'b0;
            hdr_valid <= 1'b0;
            drop      <= 1'b0;
            cnt_inc   <= 1'b0;

            if (in_valid) begin
                if (in_sop) begin
                    out_abort <= (state == ST_PAYLOAD);
                    if (in_eop) begin
                        drop        <= 1'b1;
                        drop_reason <= DROP_HEADER;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_ETH;
                        idx   <= 5'd1;
                    end
                end else begin
                    case (state)
                        ST_ETH, ST_VLAN: begin
                            idx <= idx + 5'd1;
                            if (idx == type_end_idx - 5'd1)
                                type_msb <= in_data;
                            if ((idx == type_end_idx) && !type_ok && !type_vlan) begin
                                drop        <= 1'b1;
                                drop_reason <= DROP_ETHERTYPE;
                                state       <= rest_state;
                            end else if (in_eop) begin
                                drop        <= 1'b1;
                                drop_reason <= DROP_HEADER;
                                state       <= ST_IDLE;
                            end else if (idx == type_end_idx) begin
                                if (type_ok) begin
                                    state <= ST_ECPRI;
                                    idx   <= '0;
                                end else begin
                                    state <= ST_VLAN;
                                end
                            end
                        end

                        ST_ECPRI: begin
                            idx <= idx + 5'd1;
                            case (idx)
                                5'd0:    ecpri_b0      <= in_data;
                                5'd1:    msg_q         <= in_data;
                                5'd2:    size_q[15:8]  <= in_data;
                                5'd3:    size_q[7:0]   <= in_data;
                                5'd4:    pcid_q[15:8]  <= in_data;
                                5'd5:    pcid_q[7:0]   <= in_data;
                                5'd6:    seq_msb       <= in_data;
                                default: ;
                            endcase
                            if (idx == ECPRI_HDR_LAST) begin
                                hdr_valid        <= 1'b1;
                                hdr_msg_type     <= msg_q;
                                hdr_payload_size <= size_q;
                                hdr_pc_id        <= pcid_q;
                                hdr_seq_id       <= {seq_msb, in_data};
                                if (hdr_fail) begin
                                    drop        <= 1'b1;
                                    drop_reason <= hdr_reason;
                                    state       <= rest_state;
                                end else if (size_q == ECPRI_SIZE_HDR) begin
                                    // Header-only message: nothing to forward, count it now.
                                    cnt_inc <= 1'b1;
                                    cnt_ch  <= pcid_q[CH_W-1:0];
                                    state   <= rest_state;
                                end else begin
                                    state   <= ST_PAYLOAD;
                                    rem     <= size_q - ECPRI_SIZE_HDR;
                                    first_q <= 1'b1;
                                    out_ch  <= pcid_q[CH_W-1:0];
                                end
                            end else if (in_eop) begin
                                drop        <= 1'b1;
                                drop_reason <= DROP_HEADER;
                                state       <= ST_IDLE;
                            end
                        end

                        ST_PAYLOAD: begin
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_sop   <= first_q;
                            first_q   <= 1'b0;
                            rem       <= rem - 16'd1;
                            if ((rem == 16'd1) || in_eop) begin
                                out_eop <= 1'b1;
                                out_err <= (rem != 16'd1);
                                if (rem == 16'd1) begin
                                    cnt_inc <= 1'b1;
                                    cnt_ch  <= out_ch;
                                end
                                state <= rest_state;
                            end
                        end

                        ST_FLUSH: begin
                            if (in_eop) state <= ST_IDLE;
                        end

                        default: ;
                    endcase
                end
            end
        end
    end

    ecpri_ch_counters #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_counters (
        .clk      (clk),
        .rst      (rst),
        .inc      (cnt_inc),
        .inc_ch   (cnt_ch),
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt)
    );

endmodule

// File: tb/tb_ecpri_rx_parser.sv
// Directed self-checking bench for ecpri_rx_parser (both with and without ECPRI_VLAN_EN).
module tb_ecpri_rx_parser;
    import ecpri_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 2;

    typedef logic [7:0] bq_t [$];

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_sop;
    logic             in_eop;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sop;
    logic             out_eop;
    logic             out_err;
    logic             out_abort;
    logic [CH_W-1:0]  out_ch;
    logic             hdr_valid;
    logic [7:0]       hdr_msg_type;
    logic [15:0]      hdr_payload_size;
    logic [15:0]      hdr_pc_id;
    logic [15:0]      hdr_seq_id;
    logic             drop;
    logic [1:0]       drop_reason;
    logic [CH_W-1:0]  stat_sel;
    logic [CNT_W-1:0] stat_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor state
    logic [7:0] ob[$];
    logic       osop[$];
    logic       oeop[$];
    logic       oerr[$];
    logic [1:0] och[$];
    int         ocyc[$];
    int         in_cyc[$];
    int         n_hdr, n_drop, n_abort, h_cyc, d_cyc;
    logic [7:0]  h_type;
    logic [15:0] h_size, h_pcid, h_seq;
    logic [1:0]  d_reason;

    ecpri_rx_parser #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_sop           (in_sop),
        .in_eop           (in_eop),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_sop          (out_sop),
        .out_eop          (out_eop),
        .out_err          (out_err),
        .out_abort        (out_abort),
        .out_ch           (out_ch),
        .hdr_valid        (hdr_valid),
        .hdr_msg_type     (hdr_msg_type),
        .hdr_payload_size (hdr_payload_size),
        .hdr_pc_id        (hdr_pc_id),
        .hdr_seq_id       (hdr_seq_id),
        .drop             (drop),
        .drop_reason      (drop_reason),
        .stat_sel         (stat_sel),
        .stat_cnt         (stat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                ob.push_back(out_data);
                osop.push_back(out_sop);
                oeop.push_back(out_eop);
                oerr.push_back(out_err);
                och.push_back(out_ch);
                ocyc.push_back(cyc);
            end
            if (hdr_valid) begin
                n_hdr++;
                h_cyc  = cyc;
                h_type = hdr_msg_type;
                h_size = hdr_payload_size;
                h_pcid = hdr_pc_id;
                h_seq  = hdr_seq_id;
            end
            if (drop) begin
                n_drop++;
                d_cyc    = cyc;
                d_reason = drop_reason;
            end
            if (out_abort) n_abort++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int i);
        return 8'hA0 + 8'(i * 3);
    endfunction

    function automatic bq_t make_frame(input logic [15:0] etype, input logic [7:0] b0,
                                       input logic [7:0] msg, input logic [15:0] size,
                                       input logic [15:0] pcid, input logic [15:0] seq,
                                       input int npay, input int npad, input bit vlan);
        bq_t f;
        for (int i = 0; i < 6; i++) f.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 6; i++) f.push_back(8'h20 + 8'(i));
        if (vlan) begin
            f.push_back(8'h81); f.push_back(8'h00);
            f.push_back(8'h01); f.push_back(8'h23);
        end
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        f.push_back(b0);          f.push_back(msg);
        f.push_back(size[15:8]);  f.push_back(size[7:0]);
        f.push_back(pcid[15:8]);  f.push_back(pcid[7:0]);
        f.push_back(seq[15:8]);   f.push_back(seq[7:0]);
        for (int i = 0; i < npay; i++) f.push_back(pay_byte(i));
        for (int i = 0; i < npad; i++) f.push_back(8'h00);
        return f;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bq_t f, input int gap_every, input bit with_eop);
        in_cyc.delete();
        for (int i = 0; i < f.size(); i++) begin
            if (gap_every > 0 && i > 0 && (i % gap_every) == 0) begin
                in_valid = 1'b0;
                idle(1);
            end
            in_valid = 1'b1;
            in_data  = f[i];
            in_sop   = (i == 0);
            in_eop   = with_eop && (i == f.size() - 1);
            in_cyc.push_back(cyc);
            idle(1);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic clear_mon();
        ob.delete(); osop.delete(); oeop.delete(); oerr.delete(); och.delete(); ocyc.delete();
        n_hdr = 0; n_drop = 0; n_abort = 0; h_cyc = -1; d_cyc = -1;
    endtask

    task automatic read_cnt(input int ch, output logic [CNT_W-1:0] val);
        stat_sel = CH_W'(ch);
        idle(2);
        val = stat_cnt;
    endtask

    task automatic check_cnt(input string tag, input int ch, input logic [31:0] exp);
        logic [CNT_W-1:0] v;
        read_cnt(ch, v);
        check(tag, v, exp);
    endtask

    function automatic int count_eop();
        int n = 0;
        foreach (oeop[i]) if (oeop[i]) n++;
        return n;
    endfunction

    initial begin
        bq_t f;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        stat_sel = '0;
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_drop", drop, 0);
        check("rst_drop_reason", drop_reason, 0);
        check("rst_stat_cnt", stat_cnt, 0);
        check("rst_hdr_pc_id", hdr_pc_id, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Valid frame: pc_id 2, seq 0x0105, size 20 -> 16 payload bytes, 14 pad
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h00, 16'd20, 16'd2, 16'h0105, 16, 14, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("v_hdr_cnt", n_hdr, 1);
        check("v_hdr_type", h_type, 0);
        check("v_hdr_size", h_size, 20);
        check("v_hdr_pcid", h_pcid, 2);
        check("v_hdr_seq", h_seq, 32'h0105);
        check("v_hdr_time", h_cyc, in_cyc[21] + 1);
        check("v_drop", n_drop, 0);
        check("v_nbytes", ob.size(), 16);
        if (ob.size() == 16) begin
            for (int i = 0; i < 16; i++) check($sformatf("v_byte%0d", i), ob[i], pay_byte(i));
            check("v_sop", osop[0], 1);
            check("v_eop_last", oeop[15], 1);
            check("v_err_last", oerr[15], 0);
            check("v_ch", och[0], 2);
            check("v_ch_end", och[15], 2);
            check("v_first_time", ocyc[0], h_cyc + 1);
        end
        check("v_eop_count", count_eop(), 1);
        check_cnt("v_cnt2", 2, 1);

        // Ethertype 0x0800
        clear_mon();
        f = make_frame(16'h0800, 8'h10, 8'h00, 16'd20, 16'd0, 16'h0001, 16, 0, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("et_drop", n_drop, 1);
        check("et_reason", d_reason, DROP_ETHERTYPE);
        check("et_time", d_cyc, in_cyc[13] + 1);
        check("et_hdr", n_hdr, 0);
        check("et_nbytes", ob.size(), 0);
        check_cnt("et_cnt0", 0, 0);
        check_cnt("et_cnt2", 2, 1);

        // Revision 2
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h20, 8'h00, 16'd20, 16'd1, 16'h0002, 16, 0, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("rev_hdr", n_hdr, 1);
        check("rev_drop", n_drop, 1);
        check("rev_reason", d_reason, DROP_REVISION);
        check("rev_nbytes", ob.size(), 0);

        // msg_type 5
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h05, 16'd20, 16'd1, 16'h0003, 16, 0, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("msg_drop", n_drop, 1);
        check("msg_reason", d_reason, DROP_HEADER);
        check("msg_nbytes", ob.size(), 0);

        // pc_id = NUM_CH
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h02, 16'd20, 16'd4, 16'h0004, 16, 4, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("ch_hdr", n_hdr, 1);
        check("ch_hdr_pcid", h_pcid, 4);
        check("ch_drop", n_drop, 1);
        check("ch_reason", d_reason, DROP_CHANNEL);
        check("ch_drop_time", d_cyc, h_cyc);
        check("ch_nbytes", ob.size(), 0);
        check("ch_reason_held", drop_reason, DROP_CHANNEL);

        // Truncated after 5 of 16 payload bytes
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h00, 16'd20, 16'd1, 16'h0005, 5, 0, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("tr_nbytes", ob.size(), 5);
        if (ob.size() == 5) begin
            check("tr_eop", oeop[4], 1);
            check("tr_err", oerr[4], 1);
            check("tr_byte4", ob[4], pay_byte(4));
        end
        check("tr_eop_count", count_eop(), 1);
        check("tr_drop", n_drop, 0);
        check_cnt("tr_cnt1", 1, 0);

        // in_sop mid-payload aborts, the new frame parses normally
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h00, 16'd20, 16'd3, 16'h0006, 3, 0, 1'b0);
        send(f, 0, 1'b0);
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h01, 16'd8, 16'd3, 16'h0007, 4, 30, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("ab_abort", n_abort, 1);
        check("ab_nbytes", ob.size(), 7);
        if (ob.size() == 7) begin
            check("ab_sop2", osop[3], 1);
            check("ab_byte6", ob[6], pay_byte(3));
            check("ab_eop6", oeop[6], 1);
            check("ab_err6", oerr[6], 0);
        end
        check("ab_eop_count", count_eop(), 1);
        check("ab_hdr_seq", h_seq, 32'h0007);
        check_cnt("ab_cnt3", 3, 1);

        // in_valid gaps inside the payload propagate one-for-one
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h00, 16'd12, 16'd0, 16'h0008, 8, 2, 1'b0);
        send(f, 3, 1'b1);
        idle(4);
        check("gap_nbytes", ob.size(), 8);
        if (ob.size() == 8)
            for (int i = 0; i < 8; i++)
                check($sformatf("gap_time%0d", i), ocyc[i], in_cyc[22 + i] + 1);
        check_cnt("gap_cnt0", 0, 1);

        // payload_size = 4: no output, counted immediately
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h00, 16'd4, 16'd1, 16'h0009, 0, 6, 1'b0);
        send(f, 0, 1'b1);
        idle(4);
        check("s4_hdr", n_hdr, 1);
        check("s4_nbytes", ob.size(), 0);
        check("s4_drop", n_drop, 0);
        check_cnt("s4_cnt1", 1, 1);

        // VLAN-tagged frame
        clear_mon();
        f = make_frame(ETH_TYPE_ECPRI, 8'h10, 8'h00, 16'd8, 16'd2, 16'h000A, 4, 2, 1'b1);
        send(f, 0, 1'b1);
        idle(4);
`ifdef ECPRI_VLAN_EN
        check("vl_hdr", n_hdr, 1);
        check("vl_drop", n_drop, 0);
        check("vl_nbytes", ob.size(), 4);
        if (ob.size() == 4) begin
            check("vl_byte0", ob[0], pay_byte(0));
            check("vl_eop", oeop[3], 1);
            check("vl_time", ocyc[0], in_cyc[26] + 1);
        end
        check_cnt("vl_cnt2", 2, 2);
`else
        check("vl_drop", n_drop, 1);
        check("vl_reason", d_reason, DROP_ETHERTYPE);
        check("vl_nbytes", ob.size(), 0);
        check_cnt("vl_cnt2", 2, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
